alarm_unit: RTL and testbench
=============================

Name: alarm_unit

Overview:
- Alarm stage directly downstream of binary_clock.
- Consumes its BCD time digits and one_sec pulse.
- Holds a user-set alarm time (HH:MM) and detects the match.
- Runs a ring/snooze/stop state machine, drives a buzzer, and exports alarm digits and status to pixel_clk_gen for on-screen display.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..99)
RING_TIMEOUT_SEC, 60, auto-silence after this many one_sec pulses of ringing (1..255)
TONE_HALF, 50000, clk cycles per buzzer tone half-period (1 kHz at 100 MHz)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-low reset
one_sec  in  1  single-cycle pulse from binary_clock, once per second
sec_first, sec_second, min_first, min_second, hour_first, hour_second  in  4 each  current time, BCD; *_first = ones digit, *_second = tens digit; 24 h
set_mode  in  1  level; high = buttons edit alarm time
hour_button, min_button  in  1  raw level buttons, debounced externally
snooze_button, stop_button  in  1  raw level buttons
arm_sw  in  1  level; alarm enable switch
alarm_min_first, alarm_min_second, alarm_hour_first, alarm_hour_second  out  4 each  stored alarm time, BCD
armed  out  1  state is ARMED, RINGING or SNOOZE
ringing  out  1  state is RINGING
snoozing  out  1  state is SNOOZE
buzzer  out  1  audio square wave

Behaviour:
- All registers update on posedge clk_100MHz.
- reset==0 at an edge forces every register to its reset value, regardless of current state:
  - state DISARMED
  - alarm time 00:00
  - all outputs 0
  - counters 0
  - sync/edge flops 0
- Buttons:
  - Each of the four buttons passes through 2-FF sync plus prev flop; edge = sync2 & ~prev.
  - The action is registered on the following edge.
  - The effect is visible on outputs 3 edges after the input is first sampled high.
  - Holding a button gives exactly one action.
- Alarm set:
  - Active only when set_mode==1 and state is DISARMED or ARMED.
  - hour edge: hour += 1 BCD, 23 -> 00.
  - min edge: min += 1 BCD, 59 -> 00, no carry into hour.
  - Simultaneous hour and min edges both apply.
- Match:
  - match = (clock HH:MM == alarm HH:MM) && sec==00, registered into match_d.
  - trigger = match & ~match_d & ~set_mode.
  - Fires at most once per matching minute; stop within that second does not re-trigger.
- States and transitions, checked in this priority order:
  - Any state, arm_sw==0 -> DISARMED. Overrides all.
  - DISARMED: arm_sw==1 -> ARMED (next edge).
  - ARMED: trigger -> RINGING; ring_cnt=0; beat=1; tone counter=0, tone=0.
  - RINGING:
    - stop edge -> ARMED.
    - Else snooze edge -> SNOOZE, snooze_cnt = SNOOZE_MIN*60.
    - Else one_sec with ring_cnt==RING_TIMEOUT_SEC-1 -> ARMED.
    - Else on one_sec: ring_cnt += 1, beat toggles.
    - Stop beats snooze when simultaneous.
  - SNOOZE:
    - stop edge -> ARMED.
    - Else one_sec with snooze_cnt==1 -> RINGING (ring_cnt=0, beat=1).
    - Else on one_sec: snooze_cnt -= 1.
    - A trigger in SNOOZE is ignored.
- ringing/snoozing/armed are registered decodes of state; they change on the same edge as state.
- Latency: digits reach alarm HH:MM:00 at edge N -> ringing=1 after edge N+1.
- Buzzer:
  - In RINGING, tone toggles every TONE_HALF cycles; buzzer = tone & beat, registered.
  - Outside RINGING, buzzer=0 and the tone counter is held at 0.
- Widths:
  - snooze_cnt is 16 b.
  - ring_cnt is 8 b.
  - tone counter is wide enough for TONE_HALF-1.
  - Alarm digits are never outside BCD range.

Decomposition:
- alarm_pkg (shared header): state encodings DISARMED=2'd0, ARMED=2'd1, RINGING=2'd2, SNOOZE=2'd3; BCD limit constants HOUR_TENS_MAX=2, HOUR_WRAP=23, MIN_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module edge_sync (2-FF synchronizer + rising-edge pulse), instantiated once per button.
- FSM, alarm registers, counters and tone generator live in alarm_unit.

Test Plan:
Bench parameters: SNOOZE_MIN=1, RING_TIMEOUT_SEC=10, TONE_HALF=4; one_sec driven every 20 clks.
1. Reset then set: reset low 2 cycles -> all outputs 0, alarm 00:00. set_mode=1; 7 hour presses, 30 min presses -> alarm digits 07:30. 24 hour presses from 00 -> 00. 60 min presses from 00 -> 00.
2. Trigger: arm_sw=1, clock steps 07:29:59 -> 07:30:00 -> ringing=1 one edge later. buzzer shows period 8 clks only while beat=1. clock 07:30:00 held 20 clks -> single trigger.
3. Stop: press stop while ringing -> ringing=0, armed=1, buzzer=0. Clock still 07:30:00 -> no re-ring.
4. Snooze: press snooze -> snoozing=1. After 60 one_sec pulses -> ringing=1 again. Snooze+stop in the same cycle -> ARMED, not SNOOZE.
5. Timeout and disarm: ring with no input -> ARMED after 10th one_sec. arm_sw=0 mid-ring -> DISARMED next edge, buzzer=0.
6. Reset mid-SNOOZE -> DISARMED, alarm 00:00, snoozing=0 on the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm stage.
//   state_t        - FSM state encoding
//   *_MAX / *_WRAP - BCD limits for the stored alarm time
//   bcd_inc_hour   - 24 h BCD hour increment (23 -> 00)
//   bcd_inc_min    - BCD minute increment (59 -> 00, no carry)
//   status_of      - {armed, ringing, snoozing} decode of a state
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam int HOUR_TENS_MAX = 2;
  localparam int HOUR_WRAP     = 23;
  localparam int MIN_TENS_MAX  = 5;
  localparam int DIGIT_MAX     = 9;

  // hh = {tens, ones}
  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] hh);
    if (hh[7:4] >= 4'(HOUR_TENS_MAX) && hh[3:0] >= 4'(HOUR_WRAP % 10))
      return 8'h00;
    else if (hh[3:0] >= 4'(DIGIT_MAX))
      return {hh[7:4] + 4'd1, 4'd0};
    else
      return {hh[7:4], hh[3:0] + 4'd1};
  endfunction

  // mm = {tens, ones}
  function automatic logic [7:0] bcd_inc_min(input logic [7:0] mm);
    if (mm[3:0] >= 4'(DIGIT_MAX)) begin
      if (mm[7:4] >= 4'(MIN_TENS_MAX))
        return 8'h00;
      else
        return {mm[7:4] + 4'd1, 4'd0};
    end else begin
      return {mm[7:4], mm[3:0] + 4'd1};
    end
  endfunction

  // {armed, ringing, snoozing}
  function automatic logic [2:0] status_of(input state_t s);
    return {s != DISARMED, s == RINGING, s == SNOOZE};
  endfunction

endpackage

// File: rtl/alarm_unit_edge_sync.sv
// edge_sync: two-flop synchronizer followed by a rising-edge detector.
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset
//   i_d     - asynchronous level input (button)
//   o_pulse - one-cycle pulse on the synchronized rising edge
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: alarm stage fed by binary_clock.
//   clk_100MHz, reset (sync, active-low)
//   one_sec, sec/min/hour BCD digits - current time
//   set_mode, hour_button, min_button - alarm time editing
//   snooze_button, stop_button, arm_sw - user controls
//   alarm_* - stored alarm time (BCD)
//   armed, ringing, snoozing - registered status
//   buzzer - gated square wave
//
// state    | meaning
// DISARMED | arm_sw low, alarm ignored
// ARMED    | waiting for the clock to match the alarm time
// RINGING  | buzzer active, beat toggles each second
// SNOOZE   | silent, counting seconds down to re-ring
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int TONE_HALF        = 50000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       one_sec,
  input  logic [3:0] sec_first,
  input  logic [3:0] sec_second,
  input  logic [3:0] min_first,
  input  logic [3:0] min_second,
  input  logic [3:0] hour_first,
  input  logic [3:0] hour_second,
  input  logic       set_mode,
  input  logic       hour_button,
  input  logic       min_button,
  input  logic       snooze_button,
  input  logic       stop_button,
  input  logic       arm_sw,
  output logic [3:0] alarm_min_first,
  output logic [3:0] alarm_min_second,
  output logic [3:0] alarm_hour_first,
  output logic [3:0] alarm_hour_second,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int              TONE_W     = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [7:0]      RING_LAST  = 8'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0]     SNOOZE_LEN = 16'(SNOOZE_MIN * 60);

  logic w_hour_edge;
  logic w_min_edge;
  logic w_snooze_edge;
  logic w_stop_edge;
  logic w_match;
  logic w_trigger;

  state_t            r_state;
  logic [2:0]        r_flags;
  logic [7:0]        r_alarm_hh;
  logic [7:0]        r_alarm_mm;
  logic              r_match_d;
  logic [7:0]        r_ring_cnt;
  logic [15:0]       r_snooze_cnt;
  logic              r_beat;
  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_tone;
  logic              r_buzzer;

  edge_sync u_sync_hour   (.i_clk(clk_100MHz), .i_rst_n(reset), .i_d(hour_button),   .o_pulse(w_hour_edge));
  edge_sync u_sync_min    (.i_clk(clk_100MHz), .i_rst_n(reset), .i_d(min_button),    .o_pulse(w_min_edge));
  edge_sync u_sync_snooze (.i_clk(clk_100MHz), .i_rst_n(reset), .i_d(snooze_button), .o_pulse(w_snooze_edge));
  edge_sync u_sync_stop   (.i_clk(clk_100MHz), .i_rst_n(reset), .i_d(stop_button),   .o_pulse(w_stop_edge));

  assign w_match = ({hour_second, hour_first} == r_alarm_hh) &&
                   ({min_second, min_first} == r_alarm_mm) &&
                   (sec_second == 4'd0) && (sec_first == 4'd0);

  // Rising edge of match only, so a held 00 second cannot re-fire after stop.
  assign w_trigger = w_match & ~r_match_d & ~set_mode;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      r_state      <= DISARMED;
      r_flags      <= 3'b000;
      r_alarm_hh   <= 8'h00;
      r_alarm_mm   <= 8'h00;
      r_match_d    <= 1'b0;
      r_ring_cnt   <= 8'd0;
      r_snooze_cnt <= 16'd0;
      r_beat       <= 1'b0;
      r_tone_cnt   <= '0;
      r_tone       <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_match_d <= w_match;

      if (r_state == RINGING) begin
        if (r_tone_cnt == TONE_LAST) begin
          r_tone_cnt <= '0;
          r_tone     <= ~r_tone;
        end else begin
          r_tone_cnt <= r_tone_cnt + 1'b1;
        end
        r_buzzer <= r_tone & r_beat;
      end else begin
        r_tone_cnt <= '0;
        r_tone     <= 1'b0;
        r_buzzer   <= 1'b0;
      end

      if (set_mode && (r_state == DISARMED || r_state == ARMED)) begin
        if (w_hour_edge) r_alarm_hh <= bcd_inc_hour(r_alarm_hh);
        if (w_min_edge)  r_alarm_mm <= bcd_inc_min(r_alarm_mm);
      end

      // Leaving RINGING clears the buzzer on the same edge as the state change.
      if (!arm_sw) begin
        r_state  <= DISARMED;
        r_flags  <= status_of(DISARMED);
        r_buzzer <= 1'b0;
      end else begin
        case (r_state)
          DISARMED: begin
            r_state <= ARMED;
            r_flags <= status_of(ARMED);
          end
          ARMED: begin
            if (w_trigger) begin
              r_state    <= RINGING;
              r_flags    <= status_of(RINGING);
              r_ring_cnt <= 8'd0;
              r_beat     <= 1'b1;
            end
          end
          RINGING: begin
            if (w_stop_edge) begin
              r_state  <= ARMED;
              r_flags  <= status_of(ARMED);
              r_buzzer <= 1'b0;
            end else if (w_snooze_edge) begin
              r_state      <= SNOOZE;
              r_flags      <= status_of(SNOOZE);
              r_snooze_cnt <= SNOOZE_LEN;
              r_buzzer     <= 1'b0;
            end else if (one_sec) begin
              if (r_ring_cnt == RING_LAST) begin
                r_state  <= ARMED;
                r_flags  <= status_of(ARMED);
                r_buzzer <= 1'b0;
              end else begin
                r_ring_cnt <= r_ring_cnt + 8'd1;
                r_beat     <= ~r_beat;
              end
            end
          end
          SNOOZE: begin
            if (w_stop_edge) begin
              r_state <= ARMED;
              r_flags <= status_of(ARMED);
            end else if (one_sec) begin
              if (r_snooze_cnt == 16'd1) begin
                r_state    <= RINGING;
                r_flags    <= status_of(RINGING);
                r_ring_cnt <= 8'd0;
                r_beat     <= 1'b1;
              end else begin
                r_snooze_cnt <= r_snooze_cnt - 16'd1;
              end
            end
          end
          default: begin
            r_state <= DISARMED;
            r_flags <= status_of(DISARMED);
          end
        endcase
      end
    end
  end

  assign {alarm_hour_second, alarm_hour_first} = r_alarm_hh;
  assign {alarm_min_second, alarm_min_first}   = r_alarm_mm;
  assign {armed, ringing, snoozing}            = r_flags;
  assign buzzer                                = r_buzzer;

endmodule

// File: tb/tb_alarm_unit.sv
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_sec = 1'b0;
  logic [3:0] sec_first = 4'd0, sec_second = 4'd0;
  logic [3:0] min_first = 4'd0, min_second = 4'd0;
  logic [3:0] hour_first = 4'd0, hour_second = 4'd0;
  logic       set_mode = 1'b0;
  logic       hour_button = 1'b0, min_button = 1'b0;
  logic       snooze_button = 1'b0, stop_button = 1'b0;
  logic       arm_sw = 1'b0;
  logic [3:0] alarm_min_first, alarm_min_second, alarm_hour_first, alarm_hour_second;
  logic       armed, ringing, snoozing, buzzer;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_unit #(.SNOOZE_MIN(1), .RING_TIMEOUT_SEC(10), .TONE_HALF(4)) dut (
    .clk_100MHz(clk), .reset(reset), .one_sec(one_sec),
    .sec_first(sec_first), .sec_second(sec_second),
    .min_first(min_first), .min_second(min_second),
    .hour_first(hour_first), .hour_second(hour_second),
    .set_mode(set_mode), .hour_button(hour_button), .min_button(min_button),
    .snooze_button(snooze_button), .stop_button(stop_button), .arm_sw(arm_sw),
    .alarm_min_first(alarm_min_first), .alarm_min_second(alarm_min_second),
    .alarm_hour_first(alarm_hour_first), .alarm_hour_second(alarm_hour_second),
    .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  logic [15:0] w_alarm;
  logic [3:0]  w_stat;  // {armed, ringing, snoozing, buzzer}
  assign w_alarm = {alarm_hour_second, alarm_hour_first, alarm_min_second, alarm_min_first};
  assign w_stat  = {armed, ringing, snoozing, buzzer};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic h, input logic m, input logic sn, input logic st);
    hour_button = h; min_button = m; snooze_button = sn; stop_button = st;
    tick(3);
  endtask

  task automatic release_all();
    hour_button = 0; min_button = 0; snooze_button = 0; stop_button = 0;
    tick(3);
  endtask

  task automatic press_n(input logic h, input logic m, input int n);
    repeat (n) begin
      hold(h, m, 1'b0, 1'b0);
      release_all();
    end
  endtask

  task automatic pulse_sec(input int n);
    repeat (n) begin
      tick(19);
      one_sec = 1'b1;
      tick(1);
      one_sec = 1'b0;
    end
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    {hour_second, hour_first} = hh;
    {min_second, min_first}   = mm;
    {sec_second, sec_first}   = ss;
  endtask

  // Step the clock into 07:30:00; ringing is expected one edge later.
  task automatic ring_now();
    set_time(8'h07, 8'h29, 8'h59);
    tick(1);
    set_time(8'h07, 8'h30, 8'h00);
    tick(1);
  endtask

  logic [15:0] buz_win;

  initial begin
    // 1. reset and alarm setting
    tick(2);
    check("reset_status", w_stat, 4'b0000);
    check("reset_alarm", w_alarm, 16'h0000);
    reset = 1'b1;
    set_mode = 1'b1;
    tick(1);

    hour_button = 1'b1;
    tick(2);
    check("btn_latency_2", w_alarm, 16'h0000);
    tick(1);
    check("btn_latency_3", w_alarm, 16'h0100);
    tick(5);
    check("btn_hold_once", w_alarm, 16'h0100);
    release_all();
    press_n(1'b1, 1'b0, 22);
    check("hour_23", w_alarm, 16'h2300);
    press_n(1'b1, 1'b0, 1);
    check("hour_wrap", w_alarm, 16'h0000);
    press_n(1'b0, 1'b1, 59);
    check("min_59", w_alarm, 16'h0059);
    press_n(1'b0, 1'b1, 1);
    check("min_wrap_nocarry", w_alarm, 16'h0000);
    press_n(1'b1, 1'b0, 6);
    press_n(1'b0, 1'b1, 29);
    check("set_0629", w_alarm, 16'h0629);
    press_n(1'b1, 1'b1, 1);
    check("simul_0730", w_alarm, 16'h0730);
    set_mode = 1'b0;

    // 2. trigger and buzzer
    arm_sw = 1'b1;
    tick(1);
    check("armed", w_stat, 4'b1000);
    set_time(8'h07, 8'h29, 8'h59);
    tick(1);
    check("no_ring_early", w_stat, 4'b1000);
    set_time(8'h07, 8'h30, 8'h00);
    tick(1);
    check("ring_latency", w_stat, 4'b1100);
    buz_win = '0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      buz_win[k] = buzzer;
    end
    check("buzzer_period8", buz_win, 16'hF0F0);
    pulse_sec(1);
    tick(1);
    buz_win = '0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      buz_win[k] = buzzer;
    end
    check("buzzer_beat0", buz_win, 16'h0000);
    check("still_ringing", w_stat[2], 1'b1);

    // 3. stop, no re-ring at same second
    hold(1'b0, 1'b0, 1'b0, 1'b1);
    check("stop", w_stat, 4'b1000);
    release_all();
    tick(30);
    check("no_rering", w_stat, 4'b1000);

    // 4. snooze
    ring_now();
    check("ring2", w_stat[2], 1'b1);
    hold(1'b0, 1'b0, 1'b1, 1'b0);
    check("snooze", w_stat, 4'b1010);
    release_all();
    pulse_sec(1);
    ring_now();
    check("snooze_ignores_trig", w_stat, 4'b1010);
    pulse_sec(58);
    check("snooze_59", w_stat, 4'b1010);
    pulse_sec(1);
    check("snooze_rering", w_stat[3:1], 3'b110);
    hold(1'b0, 1'b0, 1'b1, 1'b1);
    check("stop_beats_snooze", w_stat, 4'b1000);
    release_all();

    // 5. timeout and disarm
    ring_now();
    check("ring3", w_stat[2], 1'b1);
    pulse_sec(9);
    check("ring_9s", w_stat[3:1], 3'b110);
    pulse_sec(1);
    check("timeout", w_stat, 4'b1000);
    ring_now();
    tick(5);
    check("buzzer_on", w_stat, 4'b1101);
    arm_sw = 1'b0;
    tick(1);
    check("disarm", w_stat, 4'b0000);

    // 6. reset mid-snooze
    arm_sw = 1'b1;
    tick(1);
    ring_now();
    hold(1'b0, 1'b0, 1'b1, 1'b0);
    check("snooze2", w_stat, 4'b1010);
    reset = 1'b0;
    tick(1);
    check("reset_snooze_stat", w_stat, 4'b0000);
    check("reset_snooze_alarm", w_alarm, 16'h0000);
    reset = 1'b1;
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
